// File: rtl/instruction_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_pkg
// Shared definitions for the instruction fetch unit: datapath width, the
// RV32I canonical NOP (ADDI x0,x0,0) and the 3-bit fetch FSM encodings.
// No ports.
// ---------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RV32I_NOP = 32'h0000_0013;

    // Fetch FSM encodings
    localparam logic [2:0] IFU_IDLE = 3'd0;
    localparam logic [2:0] IFU_REQ  = 3'd1;
    localparam logic [2:0] IFU_WAIT = 3'd2;
    localparam logic [2:0] IFU_HOLD = 3'd3;
    localparam logic [2:0] IFU_DROP = 3'd4;

endpackage

// File: rtl/instruction_fetch_unit_timeout.sv
// ---------------------------------------------------------------------------
// fetch_timeout_counter
// Counts cycles spent waiting for an instruction-memory response. The count
// clears on a new request, increments while enabled and saturates at
// TIMEOUT_CYCLES. Reaching the limit sets a flag that stays set until reset.
//
// Ports:
//   i_clk     : clock, rising edge
//   i_rst     : asynchronous active-high reset
//   i_clear   : restart the count (new request accepted)
//   i_enable  : count this cycle (waiting for a response)
//   o_expired : sticky timeout flag
// ---------------------------------------------------------------------------
module fetch_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    logic [TIMEOUT_W-1:0] r_count;
    logic [TIMEOUT_W-1:0] w_count_nxt;

    always_comb begin
        w_count_nxt = r_count;
        if (i_clear)
            w_count_nxt = '0;
        else if (i_enable && (r_count != LIMIT))
            w_count_nxt = r_count + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count   <= '0;
            o_expired <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            // Flag rises in the same edge the count reaches the limit
            if (i_enable && !i_clear && (w_count_nxt == LIMIT))
                o_expired <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Reads the word at the current PC from instruction memory (valid/ready
// request, one-cycle response strobe), hands it to decode over valid/ready,
// and pulses pc_advance when decode takes it. A flush abandons in-flight
// work; a response still owed by memory is drained in DROP before the next
// request so only one request is ever outstanding.
//
// Optional build macro: IFU_MISALIGN_CHECK_EN
//   defined   : a PC with [1:0]!=0 is not fetched; a NOP is delivered with
//               instr_misaligned set.
//   undefined : request address bits [1:0] are forced to zero and
//               instr_misaligned is tied low.
//
// Ports:
//   pll_1_200MHz        : clock, rising edge
//   pll_1_reset_synced  : asynchronous active-high reset
//   current_pc_address  : PC register output
//   fetch_flush         : redirect, PC changes next cycle
//   pc_advance          : pulse allowing the next-PC mux to step
//   imem_req_*          : instruction memory read request
//   imem_resp_*         : instruction memory response strobe and word
//   instr_valid/ready   : handshake to decode
//   instr_data/pc       : delivered instruction and its PC
//   instr_misaligned    : delivered slot is a misaligned-PC trap
//   fetch_timeout       : sticky memory-response timeout flag
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR      = RV32I_NOP,
    parameter int              TIMEOUT_CYCLES = 255,
    parameter int              TIMEOUT_W      = 8
) (
    input  logic            pll_1_200MHz,
    input  logic            pll_1_reset_synced,
    input  logic [XLEN-1:0] current_pc_address,
    input  logic            fetch_flush,
    output logic            pc_advance,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_address,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_misaligned,
    output logic            fetch_timeout
);

    logic [2:0]      r_state;
    logic [XLEN-1:0] r_req_pc;

    logic            w_misaligned_pc;
    logic            w_req_fire;
    logic            w_waiting;
    logic [XLEN-1:0] w_addr;

`ifdef IFU_MISALIGN_CHECK_EN
    assign w_misaligned_pc = (current_pc_address[1:0] != 2'b00);
`else
    assign w_misaligned_pc = 1'b0;
`endif

    // Address follows the live PC while requesting so a flush without a
    // handshake retargets the pending request immediately.
    assign w_addr = (r_state == IFU_REQ) ? current_pc_address : r_req_pc;

`ifdef IFU_MISALIGN_CHECK_EN
    assign imem_req_address = w_addr;
`else
    assign imem_req_address = w_addr & ~32'h3;
`endif

    assign imem_req_valid = (r_state == IFU_REQ) && !w_misaligned_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_waiting      = (r_state == IFU_WAIT) || (r_state == IFU_DROP);

    // Flush wins over ready so the PC is never stepped past a redirect
    assign pc_advance = instr_valid && instr_ready && !fetch_flush;

    always_ff @(posedge pll_1_200MHz or posedge pll_1_reset_synced) begin
        if (pll_1_reset_synced) begin
            r_state     <= IFU_IDLE;
            r_req_pc    <= '0;
            instr_valid <= 1'b0;
            instr_data  <= NOP_INSTR;
            instr_pc    <= '0;
        end else begin
            case (r_state)
                IFU_IDLE: r_state <= IFU_REQ;

                IFU_REQ: begin
                    if (w_misaligned_pc) begin
                        // Trap slot; a concurrent flush means the PC is
                        // about to change, so keep requesting instead.
                        if (!fetch_flush) begin
                            instr_valid <= 1'b1;
                            instr_data  <= NOP_INSTR;
                            instr_pc    <= current_pc_address;
                            r_state     <= IFU_HOLD;
                        end
                    end else if (w_req_fire) begin
                        r_req_pc <= current_pc_address;
                        r_state  <= fetch_flush ? IFU_DROP : IFU_WAIT;
                    end
                end

                IFU_WAIT: begin
                    if (imem_resp_valid) begin
                        if (fetch_flush) begin
                            instr_data <= NOP_INSTR;
                            r_state    <= IFU_REQ;
                        end else begin
                            instr_data  <= imem_resp_data;
                            instr_pc    <= r_req_pc;
                            instr_valid <= 1'b1;
                            r_state     <= IFU_HOLD;
                        end
                    end else if (fetch_flush) begin
                        r_state <= IFU_DROP;
                    end
                end

                IFU_HOLD: begin
                    if (fetch_flush || instr_ready) begin
                        instr_valid <= 1'b0;
                        r_state     <= IFU_REQ;
                    end
                end

                IFU_DROP: begin
                    // Stale word from before the redirect
                    if (imem_resp_valid) begin
                        instr_data <= NOP_INSTR;
                        r_state    <= IFU_REQ;
                    end
                end

                default: r_state <= IFU_IDLE;
            endcase
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    logic r_misaligned;

    always_ff @(posedge pll_1_200MHz or posedge pll_1_reset_synced) begin
        if (pll_1_reset_synced)
            r_misaligned <= 1'b0;
        else if ((r_state == IFU_REQ) && w_misaligned_pc && !fetch_flush)
            r_misaligned <= 1'b1;
        else if ((r_state == IFU_HOLD) && (fetch_flush || instr_ready))
            r_misaligned <= 1'b0;
    end

    assign instr_misaligned = r_misaligned;
`else
    assign instr_misaligned = 1'b0;
`endif

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_timeout (
        .i_clk     (pll_1_200MHz),
        .i_rst     (pll_1_reset_synced),
        .i_clear   (w_req_fire),
        .i_enable  (w_waiting),
        .o_expired (fetch_timeout)
    );

endmodule
